// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample type and bit-reversal helper for the FFT blocks
package fft_pkg;

    localparam int FFT_N   = 4;
    localparam int FFT_W   = 16;
    localparam int FFT_LEN = 1 << FFT_N;

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } sample_t;

    function automatic int unsigned bitrev(input int unsigned x, input int n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < n; i++) r = r | (((x >> (n - 1 - i)) & 32'd1) << i);
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two-bank simple dual-port RAM with a registered read port
module fft_pingpong_ram #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [N-1:0]  waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          rbank_i,
    input  logic [N-1:0]  raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**(N+1)];
    logic [DW-1:0] rdata_q;

    // write port; contents are don't-care after reset so the array is never cleared
    always_ff @(posedge clk) begin
        if (we_i) mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end

    // read register doubles as the output data register, so it is cleared on reset
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[{rbank_i, raddr_i}];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: buffer bit-reversed FFT frames and stream them out in natural order
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [N-1:0] out_idx,
    output logic         out_last
);

    logic [N-1:0]   wr_cnt_q, rd_cnt_q, out_idx_q, wr_addr;
    logic           wr_bank_q, rd_bank_q, out_valid_q, out_last_q;
    logic [1:0]     full_q, full_d;
    logic [2*W-1:0] rd_data;
    logic           acc, load, wr_done, rd_done;

    assign in_ready = !full_q[wr_bank_q];
    assign acc      = in_valid && in_ready;
    assign load     = full_q[rd_bank_q] && (!out_valid_q || out_ready);
    assign wr_done  = acc && (&wr_cnt_q);
    assign rd_done  = load && (&rd_cnt_q);
    assign wr_addr  = N'(bitrev(32'(wr_cnt_q), N));

    // a bank is marked full by the writer's last sample and freed when its last bin is loaded
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    // counters, bank pointers and the registered output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            if (acc) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (&wr_cnt_q) wr_bank_q <= !wr_bank_q;
            end
            if (load) begin
                rd_cnt_q    <= rd_cnt_q + 1'b1;
                out_idx_q   <= rd_cnt_q;
                out_last_q  <= &rd_cnt_q;
                out_valid_q <= 1'b1;
                if (&rd_cnt_q) rd_bank_q <= !rd_bank_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    fft_pingpong_ram #(.N(N), .DW(2*W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (acc),
        .wbank_i (wr_bank_q),
        .waddr_i (wr_addr),
        .wdata_i ({in_re, in_im}),
        .re_i    (load),
        .rbank_i (rd_bank_q),
        .raddr_i (rd_cnt_q),
        .rdata_o (rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_re    = rd_data[2*W-1:W];
    assign out_im    = rd_data[W-1:0];

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed and scoreboard tests for the natural-order output buffer
module tb_fft_out_reorder;
    import fft_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 16;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, out_last;
    logic signed [W-1:0] in_re = 0, in_im = 0, out_re, out_im;
    logic [N-1:0] out_idx;

    int total = 0, bad = 0;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    logic signed [W-1:0] fb_re [L];
    logic signed [W-1:0] fb_im [L];
    int fcnt = 0;
    int nat_ref [L] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_out_reorder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        fcnt = 0;
    endtask

    task automatic model_in(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        fb_re[fcnt] = re;
        fb_im[fcnt] = im;
        fcnt++;
        if (fcnt == L) begin
            for (int j = 0; j < L; j++) exp_q.push_back('{fb_re[bitrev(j, N)], fb_im[bitrev(j, N)], j});
            fcnt = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        tick();
        tick();
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        total++;
        if ({out_re, out_im, out_idx, out_last} !== {(2*W+N+1){1'b0}}) begin
            bad++; $display("FAIL rst_outputs: got re=%0d im=%0d idx=%0d last=%0b want all 0", out_re, out_im, out_idx, out_last);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_identity();
        do_reset();
        out_ready = 1;
        for (int i = 0; i < L; i++) begin
            in_valid = 1;
            in_re = W'(i);
            in_im = W'(-i);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL id_in_ready: got %0b want 1 at i=%0d", in_ready, i); end
            tick();
        end
        in_valid = 0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL id_early: out_valid got %0b want 0 one edge after last accept", out_valid); end
        tick();
        for (int j = 0; j < L; j++) begin
            total++;
            if ({out_valid, out_re, out_im, out_idx, out_last} !== {1'b1, W'(nat_ref[j]), W'(-nat_ref[j]), N'(j), j == L - 1}) begin
                bad++;
                $display("FAIL id_out: got v=%0b re=%0d im=%0d idx=%0d last=%0b want v=1 re=%0d im=%0d idx=%0d last=%0b",
                         out_valid, out_re, out_im, out_idx, out_last, nat_ref[j], -nat_ref[j], j, j == L - 1);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL id_tail: out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int seq, nout, nlast;
        bit started;
        exp_t e;
        seq = 0; nout = 0; nlast = 0; started = 0;
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 300 && nout < 64; c++) begin
            in_valid = seq < 64;
            in_re = W'(seq * 37 - 500);
            in_im = W'(seq * 11 + 3);
            if (seq < 64) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL bb_in_ready: got %0b want 1 at seq=%0d", in_ready, seq); end
            end
            if (started && nout < 64) begin
                total++;
                if (out_valid !== 1'b1) begin bad++; $display("FAIL bb_gap: out_valid got %0b want 1 after %0d outputs", out_valid, nout); end
            end
            if (out_valid) started = 1;
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bb_out: got unexpected idx=%0d want none", out_idx); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_re, out_im, out_idx, out_last} !== {e.re, e.im, N'(e.idx), e.idx == L - 1}) begin
                        bad++;
                        $display("FAIL bb_out: got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d", out_re, out_im, out_idx, out_last, e.re, e.im, e.idx);
                    end
                end
                nout++;
                if (out_last) nlast++;
            end
            tick();
        end
        total++;
        if (nout !== 64 || nlast !== 4) begin bad++; $display("FAIL bb_count: got outs=%0d lasts=%0d want 64 and 4", nout, nlast); end
    endtask

    task automatic test_backpressure();
        int seq, nout;
        exp_t e;
        seq = 0; nout = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            in_valid = seq < 48;
            in_re = W'(seq * 5 + 7);
            in_im = W'(200 - seq * 3);
            if (out_valid) begin
                total++;
                if ({out_re, out_im, out_idx, out_last} !== {exp_q[0].re, exp_q[0].im, N'(0), 1'b0}) begin
                    bad++;
                    $display("FAIL bp_hold: got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=0 last=0", out_re, out_im, out_idx, out_last, exp_q[0].re, exp_q[0].im);
                end
            end
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            tick();
        end
        total++;
        if (seq !== 32) begin bad++; $display("FAIL bp_accepts: got %0d want 32", seq); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
        out_ready = 1;
        for (int c = 0; c < 300 && nout < 48; c++) begin
            in_valid = seq < 48;
            in_re = W'(seq * 5 + 7);
            in_im = W'(200 - seq * 3);
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_out: got unexpected idx=%0d want none", out_idx); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_re, out_im, out_idx, out_last} !== {e.re, e.im, N'(e.idx), e.idx == L - 1}) begin
                        bad++;
                        $display("FAIL bp_out: got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d", out_re, out_im, out_idx, out_last, e.re, e.im, e.idx);
                    end
                end
                nout++;
            end
            tick();
        end
        total++;
        if (nout !== 48 || exp_q.size() !== 0) begin bad++; $display("FAIL bp_count: got outs=%0d left=%0d want 48 and 0", nout, exp_q.size()); end
    endtask

    task automatic test_random();
        int seq, nout, nlast;
        exp_t e;
        seq = 0; nout = 0; nlast = 0;
        do_reset();
        for (int c = 0; c < 20000 && nout < 1600; c++) begin
            in_valid = (seq < 1600) && ($urandom_range(0, 1) == 1);
            out_ready = $urandom_range(0, 1) == 1;
            in_re = W'($urandom);
            in_im = W'($urandom);
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_out: got unexpected idx=%0d want none", out_idx); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_re, out_im, out_idx, out_last} !== {e.re, e.im, N'(e.idx), e.idx == L - 1}) begin
                        bad++;
                        $display("FAIL rnd_out: got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d", out_re, out_im, out_idx, out_last, e.re, e.im, e.idx);
                    end
                end
                nout++;
                if (out_last) nlast++;
            end
            tick();
        end
        total++;
        if (nout !== 1600 || nlast !== 100) begin bad++; $display("FAIL rnd_count: got outs=%0d lasts=%0d want 1600 and 100", nout, nlast); end
    endtask

    task automatic test_reset_mid();
        int seq, nout;
        exp_t e;
        seq = 0; nout = 0;
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 100 && seq < 23; c++) begin
            in_valid = 1;
            in_re = W'(seq + 300);
            in_im = W'(-seq - 300);
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                e = exp_q.pop_front();
                if ({out_re, out_im, out_idx} !== {e.re, e.im, N'(e.idx)}) begin
                    bad++; $display("FAIL rm_pre: got re=%0d idx=%0d want re=%0d idx=%0d", out_re, out_idx, e.re, e.idx);
                end
                nout++;
            end
            tick();
        end
        total++;
        if (nout < 4 || nout > 12) begin bad++; $display("FAIL rm_state: got %0d outputs before reset want 4..12", nout); end
        in_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        model_clear();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid: got %0b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready: got %0b want 1", in_ready); end
        seq = 0; nout = 0;
        for (int c = 0; c < 200 && nout < 16; c++) begin
            in_valid = seq < 16;
            in_re = W'(1000 + seq * 9);
            in_im = W'(-2000 + seq);
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rm_out: got unexpected re=%0d idx=%0d want none", out_re, out_idx); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_re, out_im, out_idx, out_last} !== {e.re, e.im, N'(e.idx), e.idx == L - 1}) begin
                        bad++;
                        $display("FAIL rm_out: got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d", out_re, out_im, out_idx, out_last, e.re, e.im, e.idx);
                    end
                end
                nout++;
            end
            tick();
        end
        total++;
        if (nout !== 16 || out_valid !== 1'b0) begin bad++; $display("FAIL rm_count: got outs=%0d valid=%0b want 16 and 0", nout, out_valid); end
    endtask

    task automatic test_boundary();
        int seq, nout;
        bit seen;
        exp_t e;
        seq = 0; nout = 0; seen = 0;
        do_reset();
        for (int c = 0; c < 200 && !seen; c++) begin
            in_valid = seq < 32;
            in_re = W'(seq * 3 - 40);
            in_im = W'(seq * 7);
            seen = out_valid && out_last;
            out_ready = !seen;
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                e = exp_q.pop_front();
                if ({out_re, out_im, out_idx} !== {e.re, e.im, N'(e.idx)}) begin
                    bad++; $display("FAIL bd_pre: got re=%0d idx=%0d want re=%0d idx=%0d", out_re, out_idx, e.re, e.idx);
                end
                nout++;
            end
            tick();
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bd_seen: got no out_last beat want one"); end
        for (int k = 0; k < 6; k++) begin
            in_valid = seq < 32;
            in_re = W'(seq * 3 - 40);
            in_im = W'(seq * 7);
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            total++;
            if ({out_valid, out_last, out_re, out_im, out_idx} !== {1'b1, 1'b1, exp_q[0].re, exp_q[0].im, N'(15)}) begin
                bad++;
                $display("FAIL bd_hold: got v=%0b last=%0b re=%0d idx=%0d want v=1 last=1 re=%0d idx=15", out_valid, out_last, out_re, out_idx, exp_q[0].re);
            end
            tick();
        end
        out_ready = 1;
        for (int c = 0; c < 200 && nout < 32; c++) begin
            in_valid = seq < 32;
            in_re = W'(seq * 3 - 40);
            in_im = W'(seq * 7);
            if (in_valid && in_ready) begin model_in(in_re, in_im); seq++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bd_out: got unexpected idx=%0d want none", out_idx); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_re, out_im, out_idx, out_last} !== {e.re, e.im, N'(e.idx), e.idx == L - 1}) begin
                        bad++;
                        $display("FAIL bd_out: got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d", out_re, out_im, out_idx, out_last, e.re, e.im, e.idx);
                    end
                end
                if (nout == 16) begin
                    total++;
                    if (out_idx !== N'(0)) begin bad++; $display("FAIL bd_next_bin0: got idx=%0d want 0", out_idx); end
                end
                nout++;
            end
            tick();
        end
        total++;
        if (nout !== 32) begin bad++; $display("FAIL bd_count: got %0d want 32", nout); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
